// File: rtl/draw_generator_if.sv
// Handshake and result bundle between the lottery draw generator and its consumers.
interface draw_generator_if;
    logic        start;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [4:0]  W1;
    logic [4:0]  W2;
    logic [4:0]  W3;
    logic [4:0]  W4;
    logic        SYSRDY;
    logic        busy;
    logic [3:0]  rejects;

    modport master (
        output start, seed_load, seed_in,
        input  W1, W2, W3, W4, SYSRDY, busy, rejects
    );

    modport slave (
        input  start, seed_load, seed_in,
        output W1, W2, W3, W4, SYSRDY, busy, rejects
    );
endinterface

// File: rtl/draw_generator.sv
// Draws four distinct nonzero 5-bit winning numbers from a free-running Galois LFSR,
// rejecting zero and repeated candidates.
module draw_generator #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    draw_generator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [4:0]  w_q [4];
    logic [1:0]  idx_q;
    logic [3:0]  rejects_q;
    logic        sysrdy_q;
    logic        busy_q;
    logic [4:0]  cand;
    logic        dup;

    always_comb begin
        lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : '0);
    end

    // Only slots below idx_q are filled; later slots are ignored for the duplicate test.
    always_comb begin
        cand = lfsr_q[4:0];
        dup  = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < 32'(idx_q) && w_q[i] == cand) begin
                dup = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            w_q       <= '{default: '0};
            idx_q     <= '0;
            rejects_q <= '0;
            sysrdy_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else if (bus.seed_load) begin
            lfsr_q <= (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
        end else begin
            lfsr_q <= lfsr_d;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q   <= DRAW;
                        busy_q    <= 1'b1;
                        sysrdy_q  <= 1'b0;
                        w_q       <= '{default: '0};
                        idx_q     <= '0;
                        rejects_q <= '0;
                    end
                end
                DRAW: begin
                    if (cand != 5'd0 && !dup) begin
                        w_q[idx_q] <= cand;
                        idx_q      <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q  <= DONE;
                            sysrdy_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end
                    end else if (rejects_q != 4'hF) begin
                        rejects_q <= rejects_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.W1      = w_q[0];
    assign bus.W2      = w_q[1];
    assign bus.W3      = w_q[2];
    assign bus.W4      = w_q[3];
    assign bus.SYSRDY  = sysrdy_q;
    assign bus.busy    = busy_q;
    assign bus.rejects = rejects_q;
endmodule

// File: tb/tb_draw_generator.sv
// Self-checking bench for draw_generator: fixed-seed vectors, corner sequences and a
// randomized regression against a candidate-stream reference model.
module tb_draw_generator;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] m_lfsr;

    draw_generator_if bus ();

    draw_generator #(.SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w1, w2, w3, w4, rej, lat;
    } draw_t;

    typedef struct {
        logic [15:0] seed;
        int w1, w2, w3, w4, rej, lat;
    } vec_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Walk the candidate stream from the LFSR value seen on the first DRAW edge.
    function automatic draw_t predict(input logic [15:0] l0);
        draw_t r;
        int got [4];
        int k = 0;
        int n = 0;
        int c;
        bit d;
        logic [15:0] l = l0;
        r.rej = 0;
        while (k < 4 && n < 100000) begin
            c = int'(l[4:0]);
            n++;
            d = 1'b0;
            for (int j = 0; j < k; j++) if (got[j] == c) d = 1'b1;
            if (c != 0 && !d) begin
                got[k] = c;
                k++;
            end else if (r.rej < 15) begin
                r.rej++;
            end
            l = lfsr_next(l);
        end
        r.w1 = got[0]; r.w2 = got[1]; r.w3 = got[2]; r.w4 = got[3];
        r.lat = n;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        if (reset) m_lfsr = SEED;
        else if (bus.seed_load) m_lfsr = (bus.seed_in == 16'h0000) ? SEED : bus.seed_in;
        else m_lfsr = lfsr_next(m_lfsr);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name, output int lat);
        lat = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (bus.SYSRDY) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_draw(input string name, input draw_t e, input int lat);
        chk({name, "_W1"}, int'(bus.W1), e.w1);
        chk({name, "_W2"}, int'(bus.W2), e.w2);
        chk({name, "_W3"}, int'(bus.W3), e.w3);
        chk({name, "_W4"}, int'(bus.W4), e.w4);
        chk({name, "_rej"}, int'(bus.rejects), e.rej);
        chk({name, "_lat"}, lat, e.lat);
        chk({name, "_busy"}, int'(bus.busy), 0);
    endtask

    vec_t tbl [4];

    initial begin
        draw_t e;
        draw_t s1;
        int lat;
        logic [15:0] l0;
        logic [4:0] w [4];
        bit ok;

        bus.start = 1'b0; bus.seed_load = 1'b0; bus.seed_in = '0;
        reset = 1'b1;
        m_lfsr = SEED;
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk("rst_W1", int'(bus.W1), 0);
        chk("rst_W4", int'(bus.W4), 0);
        chk("rst_sysrdy", int'(bus.SYSRDY), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_rej", int'(bus.rejects), 0);

        tbl[0] = '{16'hACE1, 16, 24, 28, 14, 0, 4};
        tbl[1] = '{16'h0040, 16,  8,  4,  2, 1, 5};
        tbl[2] = '{16'h0000, 16, 24, 28, 14, 0, 4};
        tbl[3] = '{16'h0001, 16,  8, 20, 26, 6, 10};
        s1 = '{16, 24, 28, 14, 0, 4};

        for (int i = 0; i < 4; i++) begin
            bus.seed_load = 1'b1; bus.seed_in = tbl[i].seed;
            tick();
            bus.seed_load = 1'b0; bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk($sformatf("vec%0d_busy_start", i), int'(bus.busy), 1);
            chk($sformatf("vec%0d_rdy_start", i), int'(bus.SYSRDY), 0);
            wait_ready($sformatf("vec%0d", i), lat);
            e = '{tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].w4, tbl[i].rej, tbl[i].lat};
            check_draw($sformatf("vec%0d", i), e, lat);
        end

        // Reset after W2 is accepted, then an immediate start must replay the SEED draw.
        bus.seed_load = 1'b1; bus.seed_in = 16'hACE1;
        tick();
        bus.seed_load = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        chk("mid_W2", int'(bus.W2), 24);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_W1", int'(bus.W1), 0);
        chk("mid_rst_W2", int'(bus.W2), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_rdy", int'(bus.SYSRDY), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_ready("mid_redo", lat);
        check_draw("mid_redo", s1, lat);

        // start held through DRAW is ignored; start in DONE restarts.
        bus.seed_load = 1'b1; bus.seed_in = 16'hACE1;
        tick();
        bus.seed_load = 1'b0; bus.start = 1'b1;
        tick(); tick(); tick(); tick();
        chk("hold_W3", int'(bus.W3), 28);
        chk("hold_W4_empty", int'(bus.W4), 0);
        chk("hold_busy", int'(bus.busy), 1);
        bus.start = 1'b0;
        tick();
        chk("hold_rdy", int'(bus.SYSRDY), 1);
        chk("hold_W4", int'(bus.W4), 14);
        tick();
        chk("done_hold_W1", int'(bus.W1), 16);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        l0 = m_lfsr;
        chk("redraw_rdy", int'(bus.SYSRDY), 0);
        chk("redraw_W1", int'(bus.W1), 0);
        chk("redraw_busy", int'(bus.busy), 1);
        wait_ready("redraw", lat);
        check_draw("redraw", predict(l0), lat);

        for (int d = 0; d < 1000; d++) begin
            if ($urandom_range(0, 3) != 0) begin
                bus.seed_load = 1'b1;
                bus.seed_in = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
                tick();
                bus.seed_load = 1'b0;
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            l0 = m_lfsr;
            wait_ready("rnd", lat);
            e = predict(l0);
            w[0] = bus.W1; w[1] = bus.W2; w[2] = bus.W3; w[3] = bus.W4;
            ok = 1'b1;
            for (int a = 0; a < 4; a++) begin
                if (w[a] == 5'd0) ok = 1'b0;
                for (int b = a + 1; b < 4; b++) if (w[a] == w[b]) ok = 1'b0;
            end
            chk($sformatf("rnd%0d_distinct", d), int'(ok), 1);
            chk($sformatf("rnd%0d_rej_vs_lat", d), int'(bus.rejects), (lat - 4 > 15) ? 15 : lat - 4);
            if (int'(bus.W1) != e.w1 || int'(bus.W2) != e.w2 || int'(bus.W3) != e.w3 ||
                int'(bus.W4) != e.w4 || int'(bus.rejects) != e.rej || lat != e.lat) begin
                check_draw($sformatf("rnd%0d", d), e, lat);
            end else begin
                chk($sformatf("rnd%0d_model", d), lat, e.lat);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/draw_generator.md
Name: draw_generator

Overview:
Produces the four winning numbers for one lottery round. A 16-bit LFSR supplies candidates. Zero and duplicate candidates are rejected, and accepted values are registered into W1..W4. The block sits directly upstream of the lottery top: W1..W4 drive its winning-number inputs, and SYSRDY tells the bet/check stages that the draw is valid.

Parameters:
SEED, 16'hACE1, LFSR value after reset and substitute for a zero seed_in; must be nonzero.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  draw request; sampled in IDLE and DONE only
seed_load  input  1  load seed_in into LFSR this edge
seed_in  input  16  external seed value
W1  output  5  first winning number, 1..31 once SYSRDY=1
W2  output  5  second winning number
W3  output  5  third winning number
W4  output  5  fourth winning number
SYSRDY  output  1  high while W1..W4 hold a complete, valid draw
busy  output  1  high while a draw is in progress
rejects  output  4  candidates rejected in current draw, saturates at 15

Behaviour:
- Edge priority: reset > seed_load > LFSR step.
- Reset values: lfsr=SEED, W1..W4=0, SYSRDY=0, busy=0, rejects=0, idx=0, state=IDLE.
- LFSR is a right-shift Galois type with taps mask 16'hB400: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
- The LFSR steps on every edge in every state, except when reset or seed_load is active.
- seed_load=1: lfsr <= (seed_in==0) ? SEED : seed_in. State, W and flags are unchanged. A zero LFSR value can never occur.
- States are IDLE, DRAW and DONE. idx is a 2-bit slot counter.
- IDLE, start=1 -> DRAW. On that edge: busy<=1, SYSRDY<=0, W1..W4<=0, idx<=0, rejects<=0.
- IDLE, start=0 -> stay in IDLE.
- DRAW, candidate: each edge, c = current lfsr[4:0] (value before this edge's step).
- DRAW, accept: c!=0 and c differs from every slot already filled (slots 1..idx). Write W[idx+1]<=c, then idx<=idx+1.
- DRAW, reject: otherwise rejects<=min(rejects+1,15). W and idx are unchanged.
- DRAW, completion: on the edge that accepts into W4, go to DONE with SYSRDY<=1 and busy<=0.
- DRAW, start is ignored.
- Latency: minimum 4 edges from DRAW entry to SYSRDY=1. Each reject adds one edge. Termination is guaranteed by the LFSR period of 65535.
- DONE: hold W1..W4, SYSRDY=1 and rejects. start=1 behaves as in IDLE (SYSRDY falls on that edge and W clears).
- seed_load during DRAW: the new value becomes the candidate on the next edge. Slots already accepted are kept.
- reset during DRAW or DONE: all outputs take their reset values on that edge. Any partial draw is discarded.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Seed-driven draw: reset; seed_load with seed_in=16'hACE1; next cycle start=1 for one cycle. Required: W1=16, W2=24, W3=28, W4=14 on the 4 successive edges; SYSRDY=1 and busy=0 after the 4th edge; rejects=0.
2. Zero reject: seed_in=16'h0040, then start. Required: first candidate 0 is rejected (rejects=1); then W1=16, W2=8, W3=4, W4=2; SYSRDY rises 5 edges after the start edge.
3. Zero seed substitution: seed_load with seed_in=0, then start. Required: sequence identical to scenario 1 (SEED is used); the LFSR never holds 0.
4. Reset mid-draw: reset asserted after W2 is accepted. Required: next cycle W1..W4=0, SYSRDY=0, busy=0, state IDLE, lfsr=SEED; start then reproduces scenario 1.
5. Redraw and ignored start: start held high throughout DRAW has no effect. start in DONE drops SYSRDY and clears W on that edge, and a fresh draw completes.
6. Random regression: 1000 draws with random seeds and start timing. Required per draw: W1..W4 pairwise distinct, each in 1..31; rejects equals (edges in DRAW − 4), saturated at 15.
